// File: rtl/alu_pkg.sv
// Shared ALU/EX-stage definitions: controller operation codes and the
// multiply/divide unit state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_REM   = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {IDLE, CALC, DONE} md_state_t;

    function automatic logic is_md_op(input logic [3:0] op);
        return op inside {OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide sharing one accumulator and one shift register.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    md_state_t        state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic [WIDTH:0]   partial, trial;
    logic [WIDTH-1:0] acc_step, sh_step, final_res;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             signed_op, div_zero, div_ovf;

    // One iteration: MUL consumes the multiplier MSB-first from sh; divide shifts
    // the dividend out of sh while the quotient bits shift in at the bottom.
    always_comb begin
        partial = {acc_q, sh_q[WIDTH-1]};
        trial   = partial - {1'b0, opb_q};
        if (op_q == OP_MUL) begin
            acc_step = (acc_q << 1) + (sh_q[WIDTH-1] ? opb_q : '0);
            sh_step  = sh_q << 1;
        end else if (!trial[WIDTH]) begin
            acc_step = trial[WIDTH-1:0];
            sh_step  = {sh_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = partial[WIDTH-1:0];
            sh_step  = {sh_q[WIDTH-2:0], 1'b0};
        end

        case (op_q)
            OP_MUL:  final_res = acc_step;
            OP_DIV:  final_res = qneg_q ? -sh_step : sh_step;
            OP_DIVU: final_res = sh_step;
            OP_REM:  final_res = rneg_q ? -acc_step : acc_step;
            default: final_res = acc_step;
        endcase
    end

    always_comb begin
        signed_op = (op_i == OP_DIV) || (op_i == OP_REM);
        a_mag     = (signed_op && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag     = (signed_op && b_i[WIDTH-1]) ? -b_i : b_i;
        div_zero  = (op_i != OP_MUL) && (b_i == '0);
        div_ovf   = signed_op && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        opb_d    = opb_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;

        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i && is_md_op(op_i)) begin
                        op_d   = op_i;
                        acc_d  = '0;
                        cnt_d  = '0;
                        sh_d   = a_mag;
                        opb_d  = b_mag;
                        qneg_d = signed_op && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        rneg_d = signed_op && a_i[WIDTH-1];
                        if (div_zero) begin
                            result_d = (op_i == OP_DIV || op_i == OP_DIVU) ? '1 : a_i;
                            state_d  = DONE;
                        end else if (div_ovf) begin
                            result_d = (op_i == OP_DIV) ? a_i : '0;
                            state_d  = DONE;
                        end else begin
                            state_d  = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d = acc_step;
                    sh_d  = sh_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        result_d = final_res;
                        state_d  = DONE;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign busy_o   = (state_q == CALC);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed test-plan cases plus randomized
// operations checked against an arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [3:0] MUL  = 4'b1001;
    localparam logic [3:0] DIV  = 4'b1010;
    localparam logic [3:0] DIVU = 4'b1011;
    localparam logic [3:0] REM  = 4'b1100;
    localparam logic [3:0] REMU = 4'b1101;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [3:0]  op_i = 4'b0000;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] last_res = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            MUL:  return a * b;
            DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REMU: return (b == 0) ? a : a % b;
            DIV:  begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
                return 32'(sa / sb);
            end
            REM:  begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_fast(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op == MUL) return 1'b0;
        if (b == 0) return 1'b1;
        return (op == DIV || op == REM) && a == MINV && b == 32'hFFFF_FFFF;
    endfunction

    // Observe outputs on negedges; the current negedge counts as cycle 1.
    task automatic collect(input int ncyc, output int busy_cnt, output int done_at,
                           output logic [31:0] got, output bit overlap);
        busy_cnt = 0;
        done_at  = -1;
        got      = '0;
        overlap  = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (busy_o) busy_cnt++;
            if (busy_o && done_o) overlap = 1'b1;
            if (done_o && done_at < 0) begin
                done_at = c;
                got     = result_o;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        logic [31:0] exp, got;
        int          busy_cnt, done_at, exp_done, exp_busy;
        bit          overlap;
        exp      = model(op, a, b);
        exp_done = is_fast(op, a, b) ? 1 : 33;
        exp_busy = is_fast(op, a, b) ? 0 : 32;
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk);
        start_i = 1'b0;
        collect(40, busy_cnt, done_at, got, overlap);
        n_checks++;
        if (done_at !== exp_done) begin
            n_fail++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_at, exp_done);
        end
        n_checks++;
        if (busy_cnt !== exp_busy) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_busy);
        end
        n_checks++;
        if (overlap !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_done_overlap: got 1 expected 0", name);
        end
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s result: got %h expected %h (a=%h b=%h)", name, got, exp, a, b);
        end
        last_res = exp;
    endtask

    task automatic test_reset;
        #3;
        n_checks++;
        if ({busy_o, done_o, result_o} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b res=%h expected 0 0 0",
                     busy_o, done_o, result_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        run_op(MUL, 32'd7, 32'd6, "mul_7x6");
        run_op(MUL, 32'hFFFF_FFFD, 32'd5, "mul_m3x5");
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(REM, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_op(DIVU, 32'd100, 32'd7, "divu_100_7");
        run_op(REMU, 32'd100, 32'd7, "remu_100_7");
    endtask

    task automatic test_fast_path;
        run_op(DIVU, 32'd5, 32'd0, "divu_by_zero");
        run_op(REM, 32'd5, 32'd0, "rem_by_zero");
        run_op(DIV, MINV, 32'hFFFF_FFFF, "div_overflow");
        run_op(REM, MINV, 32'hFFFF_FFFF, "rem_overflow");
    endtask

    task automatic test_random;
        logic [3:0]  ops [5] = '{MUL, DIV, DIVU, REM, REMU};
        logic [31:0] a, b;
        int          sel;
        for (int i = 0; i < 30; i++) begin
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = '0;
            else if (sel == 1) begin a = MINV; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            else if (sel == 3) a = 32'($urandom_range(0, 100));
            run_op(ops[$urandom_range(0, 4)], a, b, "random");
        end
    endtask

    task automatic test_flush;
        logic [31:0] got;
        int          busy_cnt, done_at;
        bit          overlap;
        @(negedge clk);
        start_i = 1'b1; op_i = MUL; a_i = 32'd123; b_i = 32'd456;
        @(negedge clk);
        start_i = 1'b0;
        // cycle 1 now; advance to cycle 10 and flush there
        repeat (9) @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_busy_before: got %b expected 1", busy_o);
        end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_c11: got busy=%b done=%b expected 0 0", busy_o, done_o);
        end
        n_checks++;
        if (result_o !== last_res) begin
            n_fail++;
            $display("FAIL flush_result_kept: got %h expected %h", result_o, last_res);
        end
        start_i = 1'b1; op_i = DIVU; a_i = 32'd9; b_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        // cycle 12 is collect's cycle 1, so done at cycle 44 is index 33
        collect(40, busy_cnt, done_at, got, overlap);
        n_checks++;
        if (done_at !== 33) begin
            n_fail++;
            $display("FAIL flush_restart_done: got %0d expected 33", done_at);
        end
        n_checks++;
        if (got !== 32'd3) begin
            n_fail++;
            $display("FAIL flush_restart_result: got %h expected %h", got, 32'd3);
        end
        last_res = 32'd3;
    endtask

    task automatic test_start_with_flush;
        logic [31:0] got;
        int          busy_cnt, done_at;
        bit          overlap;
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = DIVU; a_i = 32'd50; b_i = 32'd0;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        collect(40, busy_cnt, done_at, got, overlap);
        n_checks++;
        if (busy_cnt !== 0 || done_at !== -1) begin
            n_fail++;
            $display("FAIL start_flush_ignored: got busy=%0d done_at=%0d expected 0 -1",
                     busy_cnt, done_at);
        end
        n_checks++;
        if (result_o !== last_res) begin
            n_fail++;
            $display("FAIL start_flush_result: got %h expected %h", result_o, last_res);
        end
    endtask

    task automatic test_illegal_op;
        logic [31:0] got;
        int          busy_cnt, done_at;
        bit          overlap;
        @(negedge clk);
        start_i = 1'b1; op_i = 4'b0010; a_i = 32'd1; b_i = 32'd2;
        @(negedge clk);
        start_i = 1'b0;
        collect(40, busy_cnt, done_at, got, overlap);
        n_checks++;
        if (busy_cnt !== 0 || done_at !== -1) begin
            n_fail++;
            $display("FAIL illegal_op_ignored: got busy=%0d done_at=%0d expected 0 -1",
                     busy_cnt, done_at);
        end
        n_checks++;
        if (result_o !== last_res) begin
            n_fail++;
            $display("FAIL illegal_op_result: got %h expected %h", result_o, last_res);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] got;
        int          busy_cnt, done_at, waited;
        bit          overlap;
        @(negedge clk);
        start_i = 1'b1; op_i = MUL; a_i = 32'd1000; b_i = 32'd1000;
        @(negedge clk);
        start_i = 1'b0;
        waited = 0;
        while (!done_o && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (done_o !== 1'b1 || result_o !== 32'd1000000) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b res=%h expected 1 %h",
                     done_o, result_o, 32'd1000000);
        end
        // held through DONE (ignored) and the following IDLE cycle (accepted)
        start_i = 1'b1; op_i = REMU; a_i = 32'd1000; b_i = 32'd7;
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_start_in_done: got busy=%b done=%b expected 0 0", busy_o, done_o);
        end
        @(negedge clk);
        start_i = 1'b0;
        collect(40, busy_cnt, done_at, got, overlap);
        n_checks++;
        if (done_at !== 33 || busy_cnt !== 32) begin
            n_fail++;
            $display("FAIL b2b_second_timing: got done_at=%0d busy=%0d expected 33 32",
                     done_at, busy_cnt);
        end
        n_checks++;
        if (got !== 32'd6) begin
            n_fail++;
            $display("FAIL b2b_second_result: got %h expected %h", got, 32'd6);
        end
        last_res = 32'd6;
    endtask

    task automatic test_reset_mid;
        int          busy_cnt, done_at;
        logic [31:0] got;
        bit          overlap;
        @(negedge clk);
        start_i = 1'b1; op_i = DIV; a_i = 32'd1000; b_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (14) @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy_before: got %b expected 1", busy_o);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, done_o, result_o} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b res=%h expected 0 0 0",
                     busy_o, done_o, result_o);
        end
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        collect(5, busy_cnt, done_at, got, overlap);
        n_checks++;
        if (busy_cnt !== 0 || done_at !== -1) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got busy=%0d done_at=%0d expected 0 -1",
                     busy_cnt, done_at);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_fast_path;
        test_flush;
        test_start_with_flush;
        test_illegal_op;
        test_back_to_back;
        test_random;
        test_reset_mid;
        run_op(DIVU, 32'd9, 32'd3, "after_reset");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
